// File: rtl/sram_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_fetch_ctrl
// Purpose  : Sequential SRAM read sequencer. Sweeps a contiguous address
//            window one word per cycle, aligns each returned word with its
//            address and presents a {data, addr, valid} stream to the router
//            array. Reports busy/done to the layer controller.
// Ports    : i_clk, i_rst (async, active-high), i_reg_clear (sync clear)
//            i_start/i_start_addr/i_word_count : sweep launch
//            i_stall                           : pauses read issue only
//            o_sram_re/o_sram_addr/i_sram_rdata: SRAM read port
//            o_data/o_addr/o_data_valid        : stream to routers
//            o_busy/o_done                     : status
// Optional : define FETCH_STALL_CNT_EN to add o_stall_cycles (16-bit,
//            saturating count of stalled FETCH cycles).
// Revision : 1.0 - initial release
// ============================================================================
module sram_fetch_ctrl #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8,
  parameter int READ_LATENCY    = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_reg_clear,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_start_addr,
  input  logic [ADDR_WIDTH-1:0]      i_word_count,
  input  logic                       i_stall,
  output logic                       o_sram_re,
  output logic [ADDR_WIDTH-1:0]      o_sram_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] i_sram_rdata,
  output logic [SRAM_DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic                       o_data_valid,
  output logic                       o_busy,
  output logic                       o_done
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]                o_stall_cycles
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] C_ONE = ADDR_WIDTH'(1);

  logic [1:0]                 r_state;
  logic [ADDR_WIDTH-1:0]      r_next_addr;
  logic [ADDR_WIDTH-1:0]      r_remaining;
  logic                       r_sram_re;
  logic [ADDR_WIDTH-1:0]      r_sram_addr;
  logic [READ_LATENCY-1:0]    r_pipe_vld;
  logic [ADDR_WIDTH-1:0]      r_pipe_addr [READ_LATENCY];
  logic [SRAM_DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic                       r_data_valid;
  logic                       r_busy;
  logic                       r_done;

  logic [1:0]            w_state_nxt;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [ADDR_WIDTH-1:0] w_rem_nxt;
  logic                  w_in_flight;
  logic                  w_ret_vld;

  // A read is in flight from its o_sram_re cycle until its data is captured.
  assign w_in_flight = r_sram_re | (|r_pipe_vld);
  assign w_ret_vld   = r_pipe_vld[READ_LATENCY-1] & ~i_reg_clear;

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_next_addr;
    w_addr_nxt   = r_next_addr;
    w_rem_nxt    = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_word_count == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            // The first read goes out on the start edge so the SRAM port
            // is busy from the very first FETCH cycle.
            w_issue      = ~i_stall;
            w_issue_addr = i_start_addr;
            w_addr_nxt   = i_stall ? i_start_addr : i_start_addr + C_ONE;
            w_rem_nxt    = i_stall ? i_word_count : i_word_count - C_ONE;
            w_state_nxt  = (~i_stall && i_word_count == C_ONE) ? S_DRAIN : S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (!i_stall) begin
          w_issue    = 1'b1;
          w_addr_nxt = r_next_addr + C_ONE;
          w_rem_nxt  = r_remaining - C_ONE;
          if (r_remaining == C_ONE) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!w_in_flight) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (i_reg_clear) begin
      w_state_nxt = S_IDLE;
      w_issue     = 1'b0;
      w_addr_nxt  = '0;
      w_rem_nxt   = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_next_addr  <= '0;
      r_remaining  <= '0;
      r_sram_re    <= 1'b0;
      r_sram_addr  <= '0;
      r_pipe_vld   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe_addr[i] <= '0;
      end
      r_data       <= '0;
      r_addr       <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_next_addr <= w_addr_nxt;
      r_remaining <= w_rem_nxt;
      r_sram_re   <= w_issue;
      if (w_issue) begin
        r_sram_addr <= w_issue_addr;
      end
      // Stage i holds the read issued i+1 cycles ago; the last stage lines
      // up with its data on i_sram_rdata. A clear kills every stage.
      r_pipe_vld[0]  <= r_sram_re & ~i_reg_clear;
      r_pipe_addr[0] <= r_sram_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1] & ~i_reg_clear;
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
      r_data_valid <= w_ret_vld;
      if (w_ret_vld) begin
        r_data <= i_sram_rdata;
        r_addr <= r_pipe_addr[READ_LATENCY-1];
      end
      r_busy <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DRAIN);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
    end else if (i_reg_clear || (r_state == S_IDLE && i_start)) begin
      r_stall_cycles <= '0;
    end else if (r_state == S_FETCH && i_stall && r_stall_cycles != 16'hFFFF) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

  assign o_sram_re    = r_sram_re;
  assign o_sram_addr  = r_sram_addr;
  assign o_data       = r_data;
  assign o_addr       = r_addr;
  assign o_data_valid = r_data_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_fetch_ctrl
// Purpose  : Self-checking bench for sram_fetch_ctrl. Four instances with
//            READ_LATENCY 1..4 share one stimulus stream; a sweep-level model
//            predicts issue, return stream, busy and done for each latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_fetch_ctrl;

  localparam int NL   = 4;
  localparam int MAXC = 8192;
  localparam int BIG  = 1 << 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] sa = '0;
  logic [7:0] wc = '0;

  logic        re_o    [NL];
  logic [7:0]  saddr_o [NL];
  logic [63:0] rdata   [NL];
  logic [63:0] data_o  [NL];
  logic [7:0]  addr_o  [NL];
  logic        dv_o    [NL];
  logic        busy_o  [NL];
  logic        done_o  [NL];
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stc_o   [NL];
`endif

  for (genvar g = 0; g < NL; g++) begin : g_lat
    sram_fetch_ctrl #(
      .SRAM_DATA_WIDTH(64),
      .ADDR_WIDTH(8),
      .READ_LATENCY(g + 1)
    ) u_dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_reg_clear(clr),
      .i_start(start),
      .i_start_addr(sa),
      .i_word_count(wc),
      .i_stall(stall),
      .o_sram_re(re_o[g]),
      .o_sram_addr(saddr_o[g]),
      .i_sram_rdata(rdata[g]),
      .o_data(data_o[g]),
      .o_addr(addr_o[g]),
      .o_data_valid(dv_o[g]),
      .o_busy(busy_o[g]),
      .o_done(done_o[g])
`ifdef FETCH_STALL_CNT_EN
      ,
      .o_stall_cycles(stc_o[g])
`endif
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: per latency, what each cycle's read port must show, plus
  // sweep-level bookkeeping (done cycle, busy window, last clear).
  bit         m_re   [NL][MAXC];
  logic [7:0] m_ad   [NL][MAXC];
  bit         d_re   [NL][MAXC];
  logic [7:0] d_ad   [NL][MAXC];
  bit          m_act  [NL];
  logic [7:0]  m_nxt  [NL];
  int          m_rem  [NL];
  int          m_done_at [NL];
  int          m_idle [NL];
  int          m_kclr [NL];
  int          m_bs   [NL];
  int          m_be   [NL];
  int          m_scnt [NL];
  logic [7:0]  m_la   [NL];
  logic [63:0] m_ld   [NL];

  function automatic logic [63:0] sram_word(input logic [7:0] a);
    return {a, ~a, a, ~a, a, ~a, a, a};  // low 16 bits = a * 16'h0101
  endfunction

  task automatic chk(input string nm, input int l, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lat=%0d cyc=%0d got=%h exp=%h", nm, l + 1, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      int lat;
      int j;
      bit ev;
      bit do_issue;
      lat = l + 1;
      if (cyc >= MAXC - 2) begin
        // out of model history; nothing more to check
      end else if (rst) begin
        d_re[l][cyc] = 1'b0;
        rdata[l] = {$urandom, $urandom};
        chk("rst_re", l, 64'(re_o[l]), 64'd0);
        chk("rst_valid", l, 64'(dv_o[l]), 64'd0);
        chk("rst_busy", l, 64'(busy_o[l]), 64'd0);
        chk("rst_done", l, 64'(done_o[l]), 64'd0);
        chk("rst_data", l, data_o[l], 64'd0);
        chk("rst_addr", l, 64'(addr_o[l]), 64'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall_cnt", l, 64'(stc_o[l]), 64'd0);
`endif
        m_act[l] = 1'b0;  m_done_at[l] = -1; m_idle[l] = cyc + 1;
        m_kclr[l] = cyc + 1; m_bs[l] = 0; m_be[l] = 0; m_scnt[l] = 0;
        m_la[l] = '0; m_ld[l] = '0; m_re[l][cyc+1] = 1'b0;
      end else begin
        // SRAM behaviour: data for the address the DUT presented lat cycles ago.
        d_re[l][cyc] = re_o[l];
        d_ad[l][cyc] = saddr_o[l];
        if (cyc >= lat && d_re[l][cyc-lat]) rdata[l] = sram_word(d_ad[l][cyc-lat]);
        else rdata[l] = {$urandom, $urandom};

        chk("sram_re", l, 64'(re_o[l]), 64'(m_re[l][cyc]));
        if (m_re[l][cyc]) chk("sram_addr", l, 64'(saddr_o[l]), 64'(m_ad[l][cyc]));

        // A word is presented lat+1 cycles after its read, unless a clear
        // or reset edge happened since the read was issued.
        j = cyc - lat - 1;
        ev = (j >= 0) && (j >= m_kclr[l]) && m_re[l][j];
        if (ev) begin
          m_la[l] = m_ad[l][j];
          m_ld[l] = sram_word(m_ad[l][j]);
        end
        chk("data_valid", l, 64'(dv_o[l]), 64'(ev));
        chk("data", l, data_o[l], m_ld[l]);
        chk("addr", l, 64'(addr_o[l]), 64'(m_la[l]));
        chk("busy", l, 64'(busy_o[l]), 64'(cyc >= m_bs[l] && cyc < m_be[l]));
        chk("done", l, 64'(done_o[l]), 64'(cyc == m_done_at[l]));
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", l, 64'(stc_o[l]), 64'(m_scnt[l]));
`endif

        // Advance the model with this cycle's inputs.
        m_re[l][cyc+1] = 1'b0;
        do_issue = 1'b0;
        if (clr) begin
          m_act[l] = 1'b0;
          if (m_done_at[l] > cyc) m_done_at[l] = -1;
          m_kclr[l] = cyc + 1;
          m_idle[l] = cyc + 1;
          if (m_be[l] > cyc + 1) m_be[l] = cyc + 1;
          m_scnt[l] = 0;
        end else if (!m_act[l] && start && cyc >= m_idle[l]) begin
          m_scnt[l] = 0;
          if (wc == 8'd0) begin
            m_done_at[l] = cyc + 1;
            m_idle[l] = cyc + 2;
          end else begin
            m_act[l] = 1'b1; m_nxt[l] = sa; m_rem[l] = int'(wc);
            m_bs[l] = cyc + 1; m_be[l] = BIG; m_done_at[l] = -1;
            do_issue = !stall;
          end
        end else if (m_act[l]) begin
          if (stall) begin
            if (m_scnt[l] < 16'hFFFF) m_scnt[l]++;
          end else begin
            do_issue = 1'b1;
          end
        end
        if (do_issue) begin
          m_re[l][cyc+1] = 1'b1;
          m_ad[l][cyc+1] = m_nxt[l];
          m_nxt[l] = m_nxt[l] + 8'd1;
          m_rem[l]--;
          if (m_rem[l] == 0) begin
            m_act[l] = 1'b0;
            m_done_at[l] = cyc + 1 + lat + 2;
            m_idle[l] = m_done_at[l] + 1;
            m_be[l] = m_done_at[l];
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] n, output int s);
    start = 1'b1; sa = a; wc = n; s = cyc;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    int s;
    int s2;
    #1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Basic sweep
    do_start(8'h10, 8'd4, s);
    tick(20);
    for (int l = 0; l < NL; l++) chk("lit_done_cycle", l, 64'(m_done_at[l]), 64'(s + 4 + l + 1 + 2));
    for (int i = 0; i < 4; i++) chk("lit_basic_addr", 0, 64'(m_ad[0][s+1+i]), 64'(8'h10 + i));

    // Stall for three cycles after the second issue
    do_start(8'h30, 8'd6, s);
    tick(1);
    stall = 1'b1;
    tick(3);
    stall = 1'b0;
    tick(25);
    for (int l = 0; l < NL; l++) chk("lit_stall_count", l, 64'(m_scnt[l]), 64'd3);
    chk("lit_stall_gap", 0, 64'({m_re[0][s+3], m_re[0][s+4], m_re[0][s+5]}), 64'd0);
    chk("lit_stall_resume", 0, 64'(m_ad[0][s+6]), 64'h32);

    // Wrap-around and zero count
    do_start(8'hFE, 8'd3, s);
    tick(20);
    chk("lit_wrap_addr", 0, 64'(m_ad[0][s+3]), 64'h00);
    do_start(8'h20, 8'd0, s);
    for (int l = 0; l < NL; l++) chk("lit_zero_done", l, 64'(m_done_at[l]), 64'(s + 1));
    tick(5);

    // Clear after the fifth issue, then a clean sweep
    do_start(8'h80, 8'd8, s);
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("lit_clear_no_done", 2, 64'(m_done_at[2]), 64'(-1));
    tick(15);
    do_start(8'h40, 8'd2, s2);
    tick(15);
    chk("lit_after_clear_done", 2, 64'(m_done_at[2]), 64'(s2 + 2 + 3 + 2));

    // Second start while busy, then async reset between edges
    do_start(8'h50, 8'd10, s);
    tick(2);
    do_start(8'h99, 8'd5, s2);
    #2;
    rst = 1'b1;
    #1;
    for (int l = 0; l < NL; l++) begin
      chk("async_rst_re", l, 64'(re_o[l]), 64'd0);
      chk("async_rst_busy", l, 64'(busy_o[l]), 64'd0);
      chk("async_rst_valid", l, 64'(dv_o[l]), 64'd0);
      chk("async_rst_data", l, data_o[l], 64'd0);
    end
    tick(2);
    rst = 1'b0;
    tick(3);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 11) == 0);
      sa    = 8'($urandom);
      wc    = 8'($urandom_range(0, 9));
      stall = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    start = 1'b0; stall = 1'b0; clr = 1'b0;
    tick(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_fetch_ctrl.md
Name: sram_fetch_ctrl

Overview:
- Sequential SRAM read sequencer directly upstream of the row-router array.
- Sweeps a programmed, contiguous input-activation address window one word per cycle and issues reads to the activation SRAM.
- Aligns each returned word with its address and presents a {data, addr, valid} stream that drives the router's i_data / i_addr / i_data_valid inputs.
- Signals busy/done to the layer controller.

Parameters:
- SRAM_DATA_WIDTH, 64, width of one SRAM word and of o_data.
- ADDR_WIDTH, 8, SRAM address width; also the width of start address and word count.
- READ_LATENCY, 1, cycles from o_sram_re high to i_sram_rdata valid; legal range 1..4.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_reg_clear  input  1  synchronous soft clear.
- i_start  input  1  single-cycle pulse; latches i_start_addr and i_word_count.
- i_start_addr  input  ADDR_WIDTH  first SRAM address of the window.
- i_word_count  input  ADDR_WIDTH  number of words to read; 0 is legal.
- i_stall  input  1  pauses issuing of new reads.
- o_sram_re  output  1  SRAM read enable.
- o_sram_addr  output  ADDR_WIDTH  SRAM read address.
- i_sram_rdata  input  SRAM_DATA_WIDTH  SRAM read data.
- o_data  output  SRAM_DATA_WIDTH  word to the routers.
- o_addr  output  ADDR_WIDTH  address of o_data.
- o_data_valid  output  1  o_data / o_addr are valid this cycle.
- o_busy  output  1  high in FETCH or DRAIN.
- o_done  output  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset values (i_rst high, asynchronous): all outputs 0, FSM in IDLE, internal address/count/pipeline registers 0.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - On i_start with i_word_count != 0: latch address and count, go to FETCH.
  - On i_start with i_word_count == 0: go directly to DONE; no read is issued.
- FETCH:
  - Each cycle with i_stall low: o_sram_re=1, o_sram_addr=current address; address += 1 and remaining -= 1.
  - With i_stall high: o_sram_re=0; address and remaining hold.
  - After the last read issues (remaining reaches 0), go to DRAIN.
- DRAIN: wait until no read is in flight, then go to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Outputs are registered: o_sram_re and o_sram_addr are driven from flops.
- Return pipeline:
  - A READ_LATENCY-deep shift register carries {valid, addr} for each issued read.
  - In the cycle a read's data is on i_sram_rdata, the {data, addr, valid} triple is registered.
  - o_data_valid therefore rises READ_LATENCY+1 cycles after the matching o_sram_re cycle.
  - o_data and o_addr hold their last value when o_data_valid=0.
- i_stall affects issue only. Reads already in flight still return and are presented; there is no back-pressure on o_data_valid.
- Address arithmetic is modulo 2^ADDR_WIDTH: start=0xFE, count=4 reads 0xFE, 0xFF, 0x00, 0x01.
- i_start while o_busy=1 or in DONE is ignored.
- i_start and i_reg_clear in the same cycle: clear wins.
- i_reg_clear:
  - Next state is IDLE.
  - All in-flight valid bits are killed: no o_data_valid after the clear edge.
  - No o_done pulse.
  - Latched parameters are zeroed.
- i_rst mid-sweep: immediate return to the reset values above.
- Throughput: at most one read issued and one word presented per cycle. A sweep of N words with no stall completes (o_done) N+READ_LATENCY+2 cycles after the i_start cycle.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- When defined:
  - Adds output port o_stall_cycles, 16 bits.
  - Counts cycles spent in FETCH with i_stall=1.
  - Saturates at 0xFFFF.
  - Cleared to 0 on an accepted i_start, on i_reg_clear and on i_rst.
  - Holds its value after DONE until the next clear.
- When undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Basic sweep: READ_LATENCY=1, start=0x10, count=4, SRAM model returns data=addr*0x0101.
  - o_sram_addr takes 0x10..0x13 on consecutive cycles.
  - o_data_valid is high for 4 consecutive cycles with o_addr 0x10..0x13 and matching data.
  - o_done pulses once; o_busy is low afterwards.
- Stall mid-sweep: count=6, i_stall high for 3 cycles after the 2nd issue.
  - o_sram_re low for exactly those 3 cycles; no address skipped or repeated.
  - Exactly 6 valid words in order.
  - With FETCH_STALL_CNT_EN defined, o_stall_cycles=3.
- Wrap and zero count:
  - start=0xFE, count=3 -> addresses 0xFE, 0xFF, 0x00.
  - start=0x20, count=0 -> o_done one cycle after the i_start cycle, o_sram_re never high.
- Clear mid-flight: READ_LATENCY=3, count=8, i_reg_clear pulsed after the 5th issue.
  - No o_data_valid from the clear edge on; no o_done; FSM in IDLE.
  - A new i_start=0x40, count=2 then runs cleanly.
- Async reset: assert i_rst between clock edges during FETCH -> all outputs 0 immediately; second i_start while busy is ignored.
- Latency sweep: repeat the basic sweep for READ_LATENCY=1..4 -> valid arrives exactly READ_LATENCY+1 cycles after each o_sram_re.
